axi_lite_cmd_arbiter: RTL
=========================

AXI_LITE_CMD_ARBITER -- requirements
Module: axi_lite_cmd_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning data width.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum WAIT cycles before abort (used only with AXI_ARB_TIMEOUT_EN).
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset: port aclk, input, 1 bit, clock, rising edge.
REQ-005 The block SHALL have port areset, input, 1 bit, asynchronous active-high reset.
REQ-006 The block SHALL have port req_valid, input, 2 bits, per-requester request pending, held until the matching req_ack.
REQ-007 The block SHALL have port req_write, input, 2 bits, per-requester direction: 1 = write, 0 = read.
REQ-008 The block SHALL have port req_addr, input, 2*ADDR_W bits, requester i address in slice i.
REQ-009 The block SHALL have port req_wdata, input, 2*DATA_W bits, requester i write data in slice i.
REQ-010 The block SHALL have port req_ack, output, 2 bits, one-cycle completion pulse to the granted requester.
REQ-011 The block SHALL have port rsp_rdata, output, DATA_W bits, read data, valid while req_ack is high.
REQ-012 The block SHALL have port rsp_err, output, 1 bit, error flag, valid while req_ack is high.
REQ-013 The block SHALL have port start_read, output, 1 bit, one-cycle read command to the AXI4-Lite master.
REQ-014 The block SHALL have port start_write, output, 1 bit, one-cycle write command to the master.
REQ-015 The block SHALL have port addr, output, ADDR_W bits, command address to the master.
REQ-016 The block SHALL have port data, output, DATA_W bits, command write data to the master.
REQ-017 The block SHALL have port m_done, input, 1 bit, master transaction-complete pulse.
REQ-018 The block SHALL have port m_rdata, input, DATA_W bits, master read data, valid with m_done.
REQ-019 The block SHALL have port m_err, input, 1 bit, master error response (SLVERR/DECERR), valid with m_done.

Function
REQ-020 The block SHALL implement FSM states IDLE, ISSUE, WAIT and RESP, with all outputs registered or decoded from state (Moore).
REQ-021 In IDLE with any req_valid set, the block SHALL grant round-robin: the requester other than last_grant wins when both are valid; it SHALL latch that requester's write/addr/wdata, then go to ISSUE.
REQ-022 In ISSUE the block SHALL assert exactly one of start_read/start_write for one cycle, with addr/data holding the latched values, then go to WAIT; start_read and start_write SHALL never be high together.
REQ-023 In WAIT, on m_done the block SHALL capture m_err and, for reads, m_rdata, then go to RESP; m_done outside WAIT SHALL be ignored.
REQ-024 In RESP the block SHALL pulse req_ack[grant] for one cycle with rsp_rdata/rsp_err valid, set last_grant=grant, then go to IDLE; rsp_rdata SHALL be 0 for writes.
REQ-025 Latency: req_valid sampled in cycle N gives start_* in N+1; m_done in cycle M gives req_ack in M+1; the minimum request-to-ack latency is 3 cycles.
REQ-026 req_valid SHALL be sampled only in IDLE; deassertion mid-transaction SHALL NOT abort it; a continuously requesting single requester SHALL be re-served with one IDLE cycle between transactions.
REQ-027 addr/data SHALL hold their last issued values outside ISSUE.

Reset
REQ-028 Asserting areset at any time SHALL immediately force IDLE, last_grant=1 (requester 0 wins first), all outputs 0 and the timeout counter to 0; any in-flight transaction SHALL be dropped without req_ack.

Configuration
REQ-029 With macro AXI_ARB_TIMEOUT_EN defined, a WAIT-cycle counter SHALL run; on reaching TIMEOUT_CYCLES without m_done, the block SHALL go to RESP with rsp_err=1 and rsp_rdata=0, and a later stray m_done SHALL be ignored.
REQ-030 Without AXI_ARB_TIMEOUT_EN, WAIT SHALL last indefinitely until m_done, no counter SHALL be built, and TIMEOUT_CYCLES SHALL be unused.

Verification
REQ-031 The bench SHALL cover: req0 read addr 0x10, m_done with m_rdata 0xDEADBEEF -> start_read for 1 cycle, addr=0x10, req_ack=01, rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-032 The bench SHALL cover: both requesters valid after reset (req0 write 0x4 data 0x55, req1 read 0x8) -> req0 served first, then req1, then alternation while both stay valid.
REQ-033 The bench SHALL cover: write completing with m_err=1 -> req_ack pulse with rsp_err=1 and rsp_rdata=0.
REQ-034 The bench SHALL cover: areset asserted in WAIT -> all outputs 0 at once, no req_ack, and the next request issued from IDLE with requester 0 priority.
REQ-035 The bench SHALL cover, with AXI_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8: m_done withheld -> req_ack after 8 WAIT cycles with rsp_err=1; m_done 2 cycles later -> ignored, no extra ack.

Source files
------------

// File: rtl/axi_lite_cmd_arbiter.sv
// Two-requester round-robin command arbiter in front of an AXI4-Lite master.
// Optional WAIT timeout is built only when AXI_ARB_TIMEOUT_EN is defined.
module axi_lite_cmd_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic [1:0]          req_valid,
  input  logic [1:0]          req_write,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          req_ack,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                start_read,
  output logic                start_write,
  output logic [ADDR_W-1:0]   addr,
  output logic [DATA_W-1:0]   data,
  input  logic                m_done,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic                grant;
  logic                grant_nxt;
  logic                last_grant;
  logic                wr;
  logic [DATA_W-1:0]   rdata;
  logic                err;
  logic                timeout_hit;

`ifdef AXI_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;

  // WAIT-cycle counter; cleared whenever the FSM is not waiting.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wait_cnt <= {CNT_W{1'b0}};
    end else if (state == WAIT && !m_done) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end else begin
      wait_cnt <= {CNT_W{1'b0}};
    end
  end

  assign timeout_hit = (state == WAIT) && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and round-robin grant selection.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    case (state)
      IDLE: begin
        if (req_valid == 2'b11) begin
          grant_nxt = ~last_grant;
        end else if (req_valid[1]) begin
          grant_nxt = 1'b1;
        end else if (req_valid[0]) begin
          grant_nxt = 1'b0;
        end else begin
          grant_nxt = grant;
        end
        if (|req_valid) begin
          state_nxt = ISSUE;
        end else begin
          state_nxt = IDLE;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (m_done || timeout_hit) begin
          state_nxt = RESP;
        end else begin
          state_nxt = WAIT;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Command latch, response capture and round-robin history.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      grant      <= 1'b0;
      last_grant <= 1'b1;
      wr         <= 1'b0;
      addr       <= {ADDR_W{1'b0}};
      data       <= {DATA_W{1'b0}};
      rdata      <= {DATA_W{1'b0}};
      err        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            grant <= grant_nxt;
            wr    <= grant_nxt ? req_write[1] : req_write[0];
            addr  <= grant_nxt ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
            data  <= grant_nxt ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
          end
        end
        WAIT: begin
          if (m_done) begin
            err   <= m_err;
            rdata <= wr ? {DATA_W{1'b0}} : m_rdata;
          end else if (timeout_hit) begin
            err   <= 1'b1;
            rdata <= {DATA_W{1'b0}};
          end
        end
        RESP:    last_grant <= grant;
        default: ;
      endcase
    end
  end

  // Strobes and response fields are pure state decodes so reset clears them at once.
  assign start_read  = (state == ISSUE) && !wr;
  assign start_write = (state == ISSUE) && wr;
  assign req_ack     = (state == RESP) ? (grant ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_rdata   = (state == RESP) ? rdata : {DATA_W{1'b0}};
  assign rsp_err     = (state == RESP) && err;

endmodule
